dp_control_sequencer: RTL and testbench

- Control-unit sequencer for register-form ARM data-processing instructions.
- Sits upstream of the RegisterFile/ARM_ALU datapath and generates the signals that datapath consumes: RSLCT, LOAD, LOADPC, IR_CU, OP, S and ALU_OUT.
- Accepts one 32-bit instruction per valid/ready handshake, checks the condition field against the current flags, and runs a fixed DECODE -> EXECUTE -> PCINC sequence.

---
 rtl/dp_control_sequencer.sv | 178 +++++++++++++++++
 tb/tb_dp_control_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dp_control_sequencer
// Brief    : Control-unit sequencer for register-form ARM data-processing
//            instructions. Accepts one instruction per valid/ready handshake,
//            evaluates the condition field against FLAGS and steps through
//            DECODE -> EXECUTE -> PCINC, driving the RegisterFile/ARM_ALU
//            control signals (RSLCT, LOAD, LOADPC, IR_CU, OP, S, ALU_OUT).
// Revision : 1.0 - initial release
// ============================================================================
module dp_control_sequencer #(
  parameter int IDLE_OP = 17,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             RESETn,
  input  logic [31:0]      INSTR,
  input  logic             INSTR_VALID,
  output logic             INSTR_READY,
  input  logic [3:0]       FLAGS,
  output logic [19:0]      RSLCT,
  output logic             LOAD,
  output logic             LOADPC,
  output logic             IR_CU,
  output logic [4:0]       OP,
  output logic             S,
  output logic             ALU_OUT,
  output logic             BUSY,
  output logic             UNDEF,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DECODE  = 2'd1;
  localparam logic [1:0] ST_EXECUTE = 2'd2;
  localparam logic [1:0] ST_PCINC   = 2'd3;

  localparam logic [4:0]       IDLE_OP_C = 5'(IDLE_OP);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q,  state_d;
  logic [31:0]      ir_q,     ir_d;
  logic             reject_q, reject_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Instruction fields of the captured IR
  logic [3:0] w_cond;
  logic [3:0] w_opcode;
  logic       w_is_test;
  logic       w_illegal;
  logic       w_cond_pass;
  logic       unused_ir_bits;

  assign w_cond    = ir_q[31:28];
  assign w_opcode  = ir_q[24:21];
  // TST/TEQ/CMP/CMN (8..11) only update flags and never write Rd
  assign w_is_test = (w_opcode[3:2] == 2'b10);
  // Shift-amount/type bits play no role for register-form without shift
  assign unused_ir_bits = ^ir_q[7:5];

  // Encodings this sequencer cannot execute
  assign w_illegal = (w_cond == 4'b1111)
                   | (ir_q[27:26] != 2'b00)
                   | ir_q[25]
                   | ir_q[4]
                   | ((ir_q[15:12] == 4'd15) & ~w_is_test);

  // Condition predicate on the live flags {N,Z,C,V}
  always_comb begin
    logic n, z, c, v;
    n = FLAGS[3];
    z = FLAGS[2];
    c = FLAGS[1];
    v = FLAGS[0];
    w_cond_pass = 1'b0;
    case (w_cond)
      4'h0: w_cond_pass = z;
      4'h1: w_cond_pass = ~z;
      4'h2: w_cond_pass = c;
      4'h3: w_cond_pass = ~c;
      4'h4: w_cond_pass = n;
      4'h5: w_cond_pass = ~n;
      4'h6: w_cond_pass = v;
      4'h7: w_cond_pass = ~v;
      4'h8: w_cond_pass = c & ~z;
      4'h9: w_cond_pass = ~c | z;
      4'hA: w_cond_pass = (n == v);
      4'hB: w_cond_pass = (n != v);
      4'hC: w_cond_pass = ~z & (n == v);
      4'hD: w_cond_pass = z | (n != v);
      4'hE: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  // Next-state, IR capture, reject flag and retired-instruction counter
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    reject_d = reject_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (INSTR_VALID) begin
          ir_d    = INSTR;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_illegal) begin
          reject_d = 1'b1;
          state_d  = ST_PCINC;
        end else if (!w_cond_pass) begin
          state_d  = ST_PCINC;
        end else begin
          state_d  = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        cnt_d   = cnt_q + CNT_ONE;
        state_d = ST_PCINC;
      end
      default: begin
        reject_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= ST_IDLE;
      ir_q     <= 32'd0;
      reject_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      reject_q <= reject_d;
      cnt_q    <= cnt_d;
    end
  end

  // Datapath control outputs decoded from the current state and IR
  always_comb begin
    RSLCT   = 20'd0;
    LOAD    = 1'b0;
    LOADPC  = 1'b0;
    IR_CU   = 1'b1;
    OP      = IDLE_OP_C;
    S       = 1'b0;
    ALU_OUT = 1'b0;
    UNDEF   = 1'b0;
    case (state_q)
      ST_EXECUTE: begin
        RSLCT   = {ir_q[19:16], ir_q[15:12], ir_q[11:8], ir_q[3:0], ir_q[19:16]};
        OP      = {1'b0, w_opcode};
        S       = ir_q[20];
        ALU_OUT = 1'b1;
        LOAD    = ~w_is_test;
      end
      ST_PCINC: begin
        LOADPC = 1'b1;
        UNDEF  = reject_q;
      end
      default: begin
        RSLCT = 20'd0;
      end
    endcase
  end

  assign INSTR_READY = (state_q == ST_IDLE);
  assign BUSY        = (state_q != ST_IDLE);
  assign INSTR_CNT   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_control_sequencer
// Brief    : Self-checking bench for dp_control_sequencer. A behavioural model
//            classifies each instruction (reject / condition skip / execute)
//            from the instruction fields and flags, and the expected control
//            outputs are checked cycle by cycle. A second instance with a
//            4-bit counter exercises counter wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_control_sequencer;

  logic        Clk = 1'b0;
  logic        RESETn;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic [3:0]  FLAGS;

  logic        INSTR_READY, LOAD, LOADPC, IR_CU, S, ALU_OUT, BUSY, UNDEF;
  logic [19:0] RSLCT;
  logic [4:0]  OP;
  logic [15:0] INSTR_CNT;

  logic        s_ready, s_load, s_loadpc, s_ir_cu, s_s, s_alu_out, s_busy, s_undef;
  logic [19:0] s_rslct;
  logic [4:0]  s_op;
  logic [3:0]  s_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int exp_cnt    = 0;

  localparam logic [30:0] IDLE_VEC = {20'h0, 1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b0, 1'b0};

  always #5 Clk = ~Clk;

  dp_control_sequencer #(.IDLE_OP(17), .CNT_W(16)) dut (
    .Clk(Clk), .RESETn(RESETn), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .FLAGS(FLAGS), .RSLCT(RSLCT), .LOAD(LOAD),
    .LOADPC(LOADPC), .IR_CU(IR_CU), .OP(OP), .S(S), .ALU_OUT(ALU_OUT),
    .BUSY(BUSY), .UNDEF(UNDEF), .INSTR_CNT(INSTR_CNT)
  );

  dp_control_sequencer #(.IDLE_OP(17), .CNT_W(4)) dut_small (
    .Clk(Clk), .RESETn(RESETn), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(s_ready), .FLAGS(FLAGS), .RSLCT(s_rslct), .LOAD(s_load),
    .LOADPC(s_loadpc), .IR_CU(s_ir_cu), .OP(s_op), .S(s_s), .ALU_OUT(s_alu_out),
    .BUSY(s_busy), .UNDEF(s_undef), .INSTR_CNT(s_cnt)
  );

  function automatic logic [30:0] obs_vec();
    return {RSLCT, LOAD, LOADPC, IR_CU, OP, S, ALU_OUT, UNDEF};
  endfunction

  // Architectural condition evaluation on {N,Z,C,V}
  function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] fl);
    bit n, z, c, v;
    n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
    case (cond)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c && !z;    9: return !c || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  // 0 = rejected, 1 = condition failed, 2 = executes
  function automatic int classify(input logic [31:0] ins, input logic [3:0] fl);
    int opc;
    bit writes;
    opc    = int'(ins[24:21]);
    writes = !(opc >= 8 && opc <= 11);
    if (ins[31:28] == 4'hF || ins[27:26] != 2'b00 || ins[25] || ins[4] ||
        (ins[15:12] == 4'hF && writes))
      return 0;
    if (!cond_holds(ins[31:28], fl))
      return 1;
    return 2;
  endfunction

  function automatic logic [30:0] exec_vec(input logic [31:0] ins);
    logic [3:0] rn, rm, rs, rd;
    int opc;
    rn = ins[19:16]; rd = ins[15:12]; rs = ins[11:8]; rm = ins[3:0];
    opc = int'(ins[24:21]);
    return {rn, rd, rs, rm, rn, !(opc >= 8 && opc <= 11), 1'b0, 1'b1,
            1'b0, ins[24:21], ins[20], 1'b1, 1'b0};
  endfunction

  // One complete instruction from an idle start (called at a falling edge)
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl, input string name);
    int cls;
    logic [30:0] exp;
    cls = classify(ins, fl);
    INSTR = ins; FLAGS = fl; INSTR_VALID = 1'b1;
    vectors++;
    if (INSTR_READY !== 1'b1 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_ready: ready=%b busy=%b expected ready=1 busy=0", name, INSTR_READY, BUSY);
    end
    @(negedge Clk);
    INSTR_VALID = 1'b0; INSTR = $urandom;
    vectors++;
    if (BUSY !== 1'b1 || INSTR_READY !== 1'b0 || obs_vec() !== IDLE_VEC) begin
      miscompares++;
      $display("FAIL %s decode: busy=%b ready=%b outs=%h expected busy=1 ready=0 outs=%h",
               name, BUSY, INSTR_READY, obs_vec(), IDLE_VEC);
    end
    @(negedge Clk);
    FLAGS = $urandom; INSTR = $urandom;
    if (cls == 2) begin
      exp = exec_vec(ins);
      vectors++;
      if (obs_vec() !== exp) begin
        miscompares++;
        $display("FAIL %s execute: outs=%h expected %h", name, obs_vec(), exp);
      end
      exp_cnt++;
      @(negedge Clk);
    end
    exp = {20'h0, 1'b0, 1'b1, 1'b1, 5'd17, 1'b0, 1'b0, (cls == 0)};
    vectors++;
    if (obs_vec() !== exp || INSTR_CNT !== 16'(exp_cnt) || s_cnt !== 4'(exp_cnt)) begin
      miscompares++;
      $display("FAIL %s pcinc: outs=%h cnt=%0d small=%0d expected outs=%h cnt=%0d small=%0d",
               name, obs_vec(), INSTR_CNT, s_cnt, exp, 16'(exp_cnt), 4'(exp_cnt));
    end
    @(negedge Clk);
    vectors++;
    if (INSTR_READY !== 1'b1 || BUSY !== 1'b0 || obs_vec() !== IDLE_VEC) begin
      miscompares++;
      $display("FAIL %s back_idle: ready=%b busy=%b outs=%h expected 1 0 %h",
               name, INSTR_READY, BUSY, obs_vec(), IDLE_VEC);
    end
  endtask

  task automatic test_reset();
    RESETn = 1'b0; INSTR_VALID = 1'b0; INSTR = 32'd0; FLAGS = 4'd0;
    #3;
    vectors++;
    if (obs_vec() !== IDLE_VEC || INSTR_READY !== 1'b1 || BUSY !== 1'b0 || INSTR_CNT !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_outs: outs=%h ready=%b busy=%b cnt=%0d expected %h 1 0 0",
               obs_vec(), INSTR_READY, BUSY, INSTR_CNT, IDLE_VEC);
    end
    @(negedge Clk); @(negedge Clk);
    RESETn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      INSTR = $urandom; FLAGS = $urandom;
      @(negedge Clk);
      vectors++;
      if (BUSY !== 1'b0 || INSTR_CNT !== 16'd0 || obs_vec() !== IDLE_VEC) begin
        miscompares++;
        $display("FAIL idle_hold: busy=%b cnt=%0d outs=%h expected 0 0 %h", BUSY, INSTR_CNT, obs_vec(), IDLE_VEC);
      end
    end
  endtask

  task automatic test_directed();
    run_instr(32'hE0802001, 4'b0000, "add");
    run_instr(32'hE1510003, 4'b0000, "cmp_s");
    run_instr(32'h00802001, 4'b0100, "addeq_pass");
    run_instr(32'h00802001, 4'b0000, "addeq_skip");
    run_instr(32'hE2802001, 4'b0000, "rej_imm");
    run_instr(32'hF0802001, 4'b0000, "rej_cond15");
    run_instr(32'hE080F001, 4'b0000, "rej_rd15");
    run_instr(32'hE0802011, 4'b0000, "rej_regshift");
    run_instr(32'hE151F003, 4'b0000, "cmp_rd15_ok");
    run_instr(32'hC0912003, 4'b0001, "addsgt_skip");
    run_instr(32'hC0912003, 4'b1001, "addsgt_pass");
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int i = 0; i < 40; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        ins[27:25] = 3'b000;
        ins[4] = 1'b0;
      end
      if (ins[31:28] == 4'hF && $urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
      run_instr(ins, 4'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] list [3];
    int k, last, start_cnt;
    bit rdy;
    list[0] = 32'hE0821003; list[1] = 32'hE0443005; list[2] = 32'hE1A06007;
    start_cnt = exp_cnt;
    k = 0; last = -1;
    INSTR = list[0]; FLAGS = 4'd0; INSTR_VALID = 1'b1;
    for (int cyc = 0; cyc < 40 && k < 3; cyc++) begin
      vectors++;
      if (INSTR_READY !== !BUSY) begin
        miscompares++;
        $display("FAIL b2b_ready_busy: ready=%b busy=%b expected ready=!busy", INSTR_READY, BUSY);
      end
      rdy = INSTR_READY;
      if (rdy) begin
        if (last >= 0) begin
          vectors++;
          if (cyc - last != 4) begin
            miscompares++;
            $display("FAIL b2b_interval: got %0d cycles expected 4", cyc - last);
          end
        end
        last = cyc;
      end
      @(negedge Clk);
      if (rdy) begin
        k++;
        exp_cnt++;
        if (k < 3) INSTR = list[k];
        else INSTR_VALID = 1'b0;
      end
    end
    for (int i = 0; i < 8 && BUSY === 1'b1; i++) @(negedge Clk);
    vectors++;
    if (k != 3 || BUSY !== 1'b0 || INSTR_CNT !== 16'(start_cnt + 3) || s_cnt !== 4'(start_cnt + 3)) begin
      miscompares++;
      $display("FAIL b2b_count: accepted=%0d busy=%b cnt=%0d small=%0d expected 3 0 %0d %0d",
               k, BUSY, INSTR_CNT, s_cnt, 16'(start_cnt + 3), 4'(start_cnt + 3));
    end
  endtask

  task automatic test_reset_mid_execute();
    INSTR = 32'hE0802001; FLAGS = 4'd0; INSTR_VALID = 1'b1;
    @(negedge Clk);
    INSTR_VALID = 1'b0;
    @(negedge Clk);
    vectors++;
    if (LOAD !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_exec_load: LOAD=%b expected 1", LOAD);
    end
    #2 RESETn = 1'b0;
    #1;
    exp_cnt = 0;
    vectors++;
    if (LOAD !== 1'b0 || BUSY !== 1'b0 || INSTR_READY !== 1'b1 || INSTR_CNT !== 16'd0 || s_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset: load=%b busy=%b ready=%b cnt=%0d small=%0d expected 0 0 1 0 0",
               LOAD, BUSY, INSTR_READY, INSTR_CNT, s_cnt);
    end
    @(negedge Clk); @(negedge Clk);
    RESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      vectors++;
      if (LOADPC !== 1'b0 || LOAD !== 1'b0 || BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet: loadpc=%b load=%b busy=%b expected 0 0 0", LOADPC, LOAD, BUSY);
      end
    end
    run_instr(32'hE0802001, 4'b0000, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_execute();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
